alu_rr_scheduler: RTL



---
 rtl/alu_rr_scheduler.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler that shares one registered-execute ALU between NREQ requesters.

// Combinational ALU: ADD/SUB/AND/OR/XOR/SHL1/SHR1/MUL(low half); flags {zero, negative, carry, overflow}.
module alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  logic [WIDTH:0]     ext;
  logic [2*WIDTH-1:0] prod;
  logic               carry;
  logic               ovf;

  // Operation decode; SUB carry is the borrow out, shifts move by one bit.
  always_comb begin
    result = '0;
    ext    = '0;
    prod   = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (op)
      4'd0: begin
        ext    = {1'b0, a} + {1'b0, b};
        result = ext[WIDTH-1:0];
        carry  = ext[WIDTH];
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      4'd1: begin
        ext    = {1'b0, a} - {1'b0, b};
        result = ext[WIDTH-1:0];
        carry  = ext[WIDTH];
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      4'd2: result = a & b;
      4'd3: result = a | b;
      4'd4: result = a ^ b;
      4'd5: begin
        result = {a[WIDTH-2:0], 1'b0};
        carry  = a[WIDTH-1];
      end
      4'd6: begin
        result = {1'b0, a[WIDTH-1:1]};
        carry  = a[0];
      end
      4'd7: begin
        prod   = (2*WIDTH)'(a) * (2*WIDTH)'(b);
        result = prod[WIDTH-1:0];
        carry  = |prod[2*WIDTH-1:WIDTH];
      end
      default: result = '0;
    endcase
    flags = {result == '0, result[WIDTH-1], carry, ovf};
  end

endmodule

module alu_rr_scheduler #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*4-1:0]     req_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_result,
  output logic [3:0]            rsp_flags,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state;
  state_t          next_state;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  grant_id;
  logic            grant_any;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [3:0]      op_code;
  logic [IDW-1:0]  op_id;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]      alu_flags;
  logic            op_err;

  alu #(.WIDTH(WIDTH)) u_alu (
    .a      (op_a),
    .b      (op_b),
    .op     (op_code),
    .result (alu_result),
    .flags  (alu_flags)
  );

  assign op_err = op_code[3];

  // Round-robin search: first valid requester at or after rr_ptr, wrapping at NREQ.
  always_comb begin
    grant_id  = '0;
    grant_any = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      int unsigned idx;
      idx = 32'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_any && req_valid[IDW'(idx)]) begin
        grant_any = 1'b1;
        grant_id  = IDW'(idx);
      end
    end
  end

  // Grant is offered only while idle.
  assign req_ready = (state == IDLE && grant_any) ? (NREQ'(1) << grant_id) : '0;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant_any) next_state = EXEC;
      EXEC:    next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand capture at grant, response capture and pointer advance at execute.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_code    <= '0;
      op_id      <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (state == IDLE && grant_any) begin
        op_a    <= req_a[grant_id*WIDTH +: WIDTH];
        op_b    <= req_b[grant_id*WIDTH +: WIDTH];
        op_code <= req_op[grant_id*4 +: 4];
        op_id   <= grant_id;
      end
      if (state == EXEC) begin
        rsp_id     <= op_id;
        rsp_err    <= op_err;
        rsp_result <= op_err ? '0 : alu_result;
        rsp_flags  <= op_err ? '0 : alu_flags;
        rr_ptr     <= (op_id == LAST_ID) ? '0 : op_id + 1'b1;
      end
    end
  end

endmodule
